// File: rtl/venus_pkg.sv
// Shared types and constants for the venus pipeline front end.
package venus_pkg;

  localparam int W_PC   = 16;
  localparam int W_INST = 32;

  // Undefined opcode 7'h7F: decode sets no control bits and reserves no registers.
  localparam logic [W_INST-1:0] BUBBLE_INST = 32'hFE00_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [W_PC-1:0]   pc;
    logic [W_INST-1:0] inst;
  } fetch_entry_t;

  function automatic logic [W_PC-1:0] pc_next(input logic [W_PC-1:0] pc);
    return pc + W_PC'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of {pc, instruction} pairs between fetch and decode.
// Flush wins over push; push and pop may happen together.
module fetch_fifo
  import venus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_data,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int W_PTR = $clog2(DEPTH);
  localparam int W_CNT = W_PTR + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [W_PTR-1:0]   r_wr_ptr;
  logic [W_PTR-1:0]   r_rd_ptr;
  logic [W_CNT-1:0]   r_count;
  logic               w_full;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_empty   = (r_count == W_CNT'(0));
  assign w_full    = (r_count == W_CNT'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~w_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + W_PTR'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + W_PTR'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + W_CNT'(1);
        2'b01:   r_count <= r_count - W_CNT'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, imem req/ack control and redirect handling,
// feeding decode from the head of fetch_fifo.
module if_stage
  import venus_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [W_PC-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [W_PC-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [W_INST-1:0] imem_data_i,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [W_PC-1:0]   br_target_i,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_value_o,
  output logic              valid_o
);

  localparam int W_CNT = $clog2(DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [W_PC-1:0]   r_fetch_pc;
  logic [W_PC-1:0]   w_fetch_pc_nxt;
  logic [W_PC-1:0]   r_disc_addr;
  logic              r_pend;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [W_CNT-1:0]  w_count;
  fetch_entry_t      w_head;
  fetch_entry_t      w_push_data;

  assign w_pop       = ~w_empty & ~stall_i;
  assign w_push      = (r_state == ST_RUN) & w_req & imem_ack_i & ~br_taken_i;
  assign w_push_data = {r_fetch_pc, imem_data_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (br_taken_i),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_empty     (w_empty)
  );

  always_comb begin
    w_req       = 1'b0;
    imem_addr_o = r_fetch_pc;
    case (r_state)
      ST_RUN:     w_req = r_pend | (w_count < W_CNT'(DEPTH)) | w_pop;
      ST_DISCARD: begin
        w_req       = 1'b1;
        imem_addr_o = r_disc_addr;
      end
      default:    w_req = 1'b0;
    endcase
  end

  assign imem_req_o = w_req;

  // A request left hanging by a redirect must still be completed, then ignored.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      ST_IDLE:    w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (br_taken_i && w_req && !imem_ack_i) w_state_nxt = ST_DISCARD;
        else                                    w_state_nxt = ST_RUN;
      end
      ST_DISCARD: begin
        if (imem_ack_i) w_state_nxt = ST_RUN;
        else            w_state_nxt = ST_DISCARD;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (br_taken_i)  w_fetch_pc_nxt = br_target_i;
    else if (w_push) w_fetch_pc_nxt = pc_next(r_fetch_pc);
    else             w_fetch_pc_nxt = r_fetch_pc;
  end

  // FSM, fetch PC, outstanding-request tracking and discard address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_disc_addr <= RESET_PC;
      r_pend      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend     <= w_req & ~imem_ack_i;
      if (r_state == ST_RUN && br_taken_i) r_disc_addr <= r_fetch_pc;
      else                                  r_disc_addr <= r_disc_addr;
    end
  end

  // Head presentation; an empty buffer shows a bubble at PC 0.
  always_comb begin
    valid_o = ~w_empty;
    if (w_empty) begin
      inst_o     = BUBBLE_INST;
      pc_value_o = '0;
    end else begin
      inst_o     = w_head.inst;
      pc_value_o = w_head.pc;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: queue-based reference model of the fetch buffer
// checked every cycle, plus hand-computed literal pins.
module tb_if_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [15:0] br_target_i = 16'h0;
  logic [31:0] inst_o;
  logic [15:0] pc_value_o;
  logic        valid_o;

  if_stage #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_ack_i  (imem_ack_i),
    .imem_data_i (imem_data_i),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .inst_o      (inst_o),
    .pc_value_o  (pc_value_o),
    .valid_o     (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  bit          m_run, m_disc, m_pend;
  logic [15:0] m_pc, m_out_addr;
  int          m_wait, lat;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] word(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_disc = 0; m_pend = 0; m_wait = 0;
    m_pc = 16'h0000; m_out_addr = 16'h0000;
  endtask

  // One cycle: drive inputs at the falling edge, compare, then advance the model.
  task automatic tick(input logic s, input logic b, input logic [15:0] t);
    bit          e_req, ack, fire, pop;
    logic [15:0] e_addr;
    stall_i = s; br_taken_i = b; br_target_i = t;
    e_req  = m_run && (m_disc || m_pend || q.size() < DEPTH || (q.size() > 0 && !s));
    e_addr = m_pend ? m_out_addr : m_pc;
    ack    = (m_wait >= lat);
    imem_ack_i  = ack;
    imem_data_i = word(e_addr);
    #1;
    chk("req", {31'd0, imem_req_o}, {31'd0, e_req});
    if (e_req) chk("addr", {16'd0, imem_addr_o}, {16'd0, e_addr});
    chk("valid", {31'd0, valid_o}, {31'd0, q.size() > 0});
    chk("inst", inst_o, (q.size() > 0) ? q[0].inst : 32'hFE00_0000);
    chk("pc", {16'd0, pc_value_o}, {16'd0, (q.size() > 0) ? q[0].pc : 16'h0000});
    @(posedge clk);
    if (!m_run) begin
      m_run = 1;
    end else begin
      fire = e_req && ack;
      pop  = q.size() > 0 && !s;
      if (e_req && !ack) begin
        m_out_addr = e_addr; m_pend = 1; m_wait++;
      end else begin
        m_pend = 0; m_wait = 0;
      end
      if (b) begin
        q.delete();
        m_disc = e_req && !ack;
        m_pc   = t;
      end else begin
        if (pop) void'(q.pop_front());
        if (fire) begin
          if (m_disc) m_disc = 0;
          else begin
            q.push_back('{m_pc, word(m_pc)});
            m_pc = m_pc + 16'd1;
          end
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] pat;
    model_reset();
    lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr_o}, 32'h0000);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'hFE00_0000);
    chk("rst_pc", {16'd0, pc_value_o}, 32'h0000);
    rst = 1'b0;

    // Zero-wait streaming from reset.
    tick(0, 0, 16'h0);
    chk("a_addr0", {16'd0, imem_addr_o}, 32'h0000);
    tick(0, 0, 16'h0);
    chk("a_pc0", {16'd0, pc_value_o}, 32'h0000);
    chk("a_addr1", {16'd0, imem_addr_o}, 32'h0001);
    tick(0, 0, 16'h0);
    chk("a_pc1", {16'd0, pc_value_o}, 32'h0001);
    tick(0, 0, 16'h0);
    chk("a_pc2", {16'd0, pc_value_o}, 32'h0002);

    // Two-cycle memory latency.
    lat = 2;
    repeat (12) tick(0, 0, 16'h0);
    lat = 0;

    // Stall fills the buffer, then release keeps order.
    tick(0, 1, 16'h0020);
    repeat (5) tick(1, 0, 16'h0);
    chk("c_pc_held", {16'd0, pc_value_o}, 32'h0020);
    chk("c_inst_held", inst_o, word(16'h0020));
    chk("c_req_full", {31'd0, imem_req_o}, 32'd0);
    tick(0, 0, 16'h0);
    chk("c_pc21", {16'd0, pc_value_o}, 32'h0021);
    tick(0, 0, 16'h0);
    chk("c_pc22", {16'd0, pc_value_o}, 32'h0022);

    // Branch with no outstanding request.
    tick(1, 1, 16'h0040);
    chk("d_valid0", {31'd0, valid_o}, 32'd0);
    chk("d_addr40", {16'd0, imem_addr_o}, 32'h0040);
    tick(0, 0, 16'h0);
    chk("d_pc40", {16'd0, pc_value_o}, 32'h0040);

    // Branch during an unacked request: old data discarded.
    tick(1, 0, 16'h0);
    tick(1, 0, 16'h0);
    lat = 2;
    tick(1, 1, 16'h0005);
    tick(0, 0, 16'h0);
    tick(0, 1, 16'h0100);
    chk("e_addr5_held", {16'd0, imem_addr_o}, 32'h0005);
    chk("e_valid0", {31'd0, valid_o}, 32'd0);
    tick(0, 0, 16'h0);
    chk("e_addr100", {16'd0, imem_addr_o}, 32'h0100);
    repeat (3) tick(0, 0, 16'h0);
    chk("e_pc100", {16'd0, pc_value_o}, 32'h0100);

    // PC wrap, then asynchronous reset mid-request.
    lat = 0;
    tick(0, 1, 16'hFFFE);
    tick(0, 0, 16'h0);
    chk("f_pcFFFE", {16'd0, pc_value_o}, 32'hFFFE);
    tick(0, 0, 16'h0);
    chk("f_pcFFFF", {16'd0, pc_value_o}, 32'hFFFF);
    tick(0, 0, 16'h0);
    chk("f_pc0000", {16'd0, pc_value_o}, 32'h0000);
    lat = 2;
    tick(1, 0, 16'h0);
    #2 rst = 1'b1;
    #1;
    chk("f_rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("f_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("f_rst_inst", inst_o, 32'hFE00_0000);
    chk("f_rst_pc", {16'd0, pc_value_o}, 32'h0000);
    chk("f_rst_addr", {16'd0, imem_addr_o}, 32'h0000);
    model_reset();
    lat = 0; stall_i = 1'b0; br_taken_i = 1'b0; imem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(0, 0, 16'h0);
    tick(0, 0, 16'h0);
    chk("g_pc0", {16'd0, pc_value_o}, 32'h0000);

    // Mixed stall pattern with one-cycle latency and a mid-stream branch.
    lat = 1;
    pat = 12'b0110_1110_0100;
    for (int i = 0; i < 12; i++) tick(pat[i], (i == 7), 16'h0A00);
    repeat (4) tick(0, 0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
